// File: rtl/tohost_pkg.sv
// tohost_pkg: shared types and helpers for the tohost test-completion monitor.
//   tohost_state_e   monitor state encoding
//   TOHOST_CSR_ADDR  default CSR address of tohost (0x51E)
//   is_tohost_pass   true for a tohost value that signals a passing test
package tohost_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } tohost_state_e;

  localparam logic [11:0] TOHOST_CSR_ADDR = 12'h51E;

  // Widest data word the helper accepts; narrower words are zero-extended
  // by the caller.
  localparam int unsigned MAX_XLEN = 64;

  // A passing tohost write is exactly 1: LSB set and test number zero.
  function automatic logic is_tohost_pass(input logic [MAX_XLEN-1:0] wdata);
    return wdata[0] && (wdata[MAX_XLEN-1:1] == '0);
  endfunction

endpackage

// File: rtl/tohost_monitor.sv
// tohost_monitor: snoops per-hart CSR write ports for writes to tohost and
// latches a pass / fail / timeout verdict under a RUN-cycle budget.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle arm pulse (ignored while running)
//   csr_we/addr/wdata per-hart CSR write port, hart h in slice h
//   busy, done        state is RUN / state is PASS, FAIL or TIMEOUT
//   pass, timed_out   state is PASS / state is TIMEOUT
//   fail_code         wdata[XLEN-1:1] of the failing write
//   fail_hart         index of the failing hart
//   hart_done         per-hart pass flags
//   cycle_count       elapsed RUN cycles, frozen at the verdict
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | not armed, waiting for start
// ST_RUN     | armed, snooping tohost writes, counting cycles
// ST_PASS    | every hart wrote a passing tohost value
// ST_FAIL    | some hart wrote a nonzero test number
// ST_TIMEOUT | budget expired with no completion
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned XLEN           = 32,
  parameter logic [11:0] TOHOST_ADDR    = TOHOST_CSR_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
  parameter int unsigned HART_W         = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_HARTS-1:0]      csr_we,
  input  logic [NUM_HARTS*12-1:0]   csr_addr,
  input  logic [NUM_HARTS*XLEN-1:0] csr_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timed_out,
  output logic [XLEN-2:0]           fail_code,
  output logic [HART_W-1:0]         fail_hart,
  output logic [NUM_HARTS-1:0]      hart_done,
  output logic [CNT_W-1:0]          cycle_count
);

  tohost_state_e          state_q, state_d;
  logic [NUM_HARTS-1:0]   hart_done_q, hart_done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [XLEN-2:0]        fail_code_q, fail_code_d;
  logic [HART_W-1:0]      fail_hart_q, fail_hart_d;

  logic [NUM_HARTS-1:0]   pass_w;
  logic [NUM_HARTS-1:0]   fail_w;
  logic [XLEN-2:0]        code_w [NUM_HARTS];
  logic                   fail_any;
  logic [XLEN-2:0]        fail_sel_code;
  logic [HART_W-1:0]      fail_sel_hart;
  logic [NUM_HARTS-1:0]   done_next;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic [XLEN-1:0] wd;
    logic            hit;
    assign wd        = csr_wdata[h*XLEN +: XLEN];
    assign hit       = csr_we[h] && (csr_addr[h*12 +: 12] == TOHOST_ADDR) && wd[0];
    assign pass_w[h] = hit && is_tohost_pass(MAX_XLEN'(wd));
    assign fail_w[h] = hit && (wd[XLEN-1:1] != '0);
    assign code_w[h] = wd[XLEN-1:1];
  end

  // Descending scan so the lowest failing hart is the last assignment.
  always_comb begin
    fail_any      = |fail_w;
    fail_sel_code = '0;
    fail_sel_hart = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (fail_w[h]) begin
        fail_sel_code = code_w[h];
        fail_sel_hart = HART_W'(h);
      end
    end
  end

  assign done_next = hart_done_q | pass_w;

  always_comb begin
    state_d     = state_q;
    hart_done_d = hart_done_q;
    cnt_d       = cnt_q;
    fail_code_d = fail_code_q;
    fail_hart_d = fail_hart_q;
    case (state_q)
      ST_RUN: begin
        // Counter always advances in RUN, so it freezes at k+1 on a verdict.
        cnt_d       = cnt_q + CNT_W'(1);
        hart_done_d = done_next;
        if (fail_any) begin
          state_d     = ST_FAIL;
          fail_code_d = fail_sel_code;
          fail_hart_d = fail_sel_hart;
        end else if (&done_next) begin
          state_d = ST_PASS;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          state_d     = ST_RUN;
          hart_done_d = '0;
          cnt_d       = '0;
          fail_code_d = '0;
          fail_hart_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hart_done_q <= '0;
      cnt_q       <= '0;
      fail_code_q <= '0;
      fail_hart_q <= '0;
    end else begin
      state_q     <= state_d;
      hart_done_q <= hart_done_d;
      cnt_q       <= cnt_d;
      fail_code_q <= fail_code_d;
      fail_hart_q <= fail_hart_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
  assign pass        = (state_q == ST_PASS);
  assign timed_out   = (state_q == ST_TIMEOUT);
  assign fail_code   = fail_code_q;
  assign fail_hart   = fail_hart_q;
  assign hart_done   = hart_done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: two monitor instances -- a 4-hart one with an 8-cycle
// budget (randomized against a reference model plus directed boundary cases)
// and a 1-hart one with the default 10000-cycle budget (directed cases).
module tb_tohost_monitor;

  localparam int NH  = 4;
  localparam int TA  = 8;
  localparam int TB  = 10000;
  localparam int CWA = $clog2(TA + 1);
  localparam int CWB = $clog2(TB + 1);

  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TO = 4;

  logic clk;
  logic rst_n;

  logic            a_start;
  logic [NH-1:0]   a_we;
  logic [NH*12-1:0] a_addr;
  logic [NH*32-1:0] a_wdata;
  logic            a_busy, a_done, a_pass, a_to;
  logic [30:0]     a_fail_code;
  logic [1:0]      a_fail_hart;
  logic [NH-1:0]   a_hart_done;
  logic [CWA-1:0]  a_cnt;

  logic            b_start;
  logic [0:0]      b_we;
  logic [11:0]     b_addr;
  logic [31:0]     b_wdata;
  logic            b_busy, b_done, b_pass, b_to;
  logic [30:0]     b_fail_code;
  logic [0:0]      b_fail_hart;
  logic [0:0]      b_hart_done;
  logic [CWB-1:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int          m_state;
  logic [3:0]  m_done;
  int          m_cnt;
  logic [30:0] m_code;
  int          m_hart;

  tohost_monitor #(.NUM_HARTS(NH), .XLEN(32), .TIMEOUT_CYCLES(TA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .csr_we(a_we), .csr_addr(a_addr), .csr_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timed_out(a_to),
    .fail_code(a_fail_code), .fail_hart(a_fail_hart),
    .hart_done(a_hart_done), .cycle_count(a_cnt)
  );

  tohost_monitor #(.NUM_HARTS(1), .XLEN(32), .TIMEOUT_CYCLES(TB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .csr_we(b_we), .csr_addr(b_addr), .csr_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timed_out(b_to),
    .fail_code(b_fail_code), .fail_hart(b_fail_hart),
    .hart_done(b_hart_done), .cycle_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_state = M_IDLE;
    m_done  = '0;
    m_cnt   = 0;
    m_code  = '0;
    m_hart  = 0;
  endtask

  // Reference model: one RUN cycle worth of rules applied to the sampled inputs.
  task automatic model_step();
    int          fh;
    logic [3:0]  pm;
    logic [31:0] d;
    if (!rst_n) begin
      m_reset();
      return;
    end
    if (m_state != M_RUN) begin
      if (a_start) begin
        m_state = M_RUN;
        m_done  = '0;
        m_cnt   = 0;
        m_code  = '0;
        m_hart  = 0;
      end
      return;
    end
    fh = -1;
    pm = '0;
    for (int h = 0; h < NH; h++) begin
      d = a_wdata[h*32 +: 32];
      if (a_we[h] && a_addr[h*12 +: 12] == 12'h51E && d[0]) begin
        if (d[31:1] == 31'd0) pm[h] = 1'b1;
        else if (fh < 0) fh = h;
      end
    end
    m_cnt  = m_cnt + 1;
    m_done = m_done | pm;
    if (fh >= 0) begin
      m_state = M_FAIL;
      m_code  = a_wdata[fh*32 + 1 +: 31];
      m_hart  = fh;
    end else if (m_done == 4'hF) begin
      m_state = M_PASS;
    end else if (m_cnt == TA) begin
      m_state = M_TO;
    end
  endtask

  task automatic check_a();
    chk("a_busy", 64'(a_busy), 64'(m_state == M_RUN));
    chk("a_done", 64'(a_done), 64'(m_state == M_PASS || m_state == M_FAIL || m_state == M_TO));
    chk("a_pass", 64'(a_pass), 64'(m_state == M_PASS));
    chk("a_timed_out", 64'(a_to), 64'(m_state == M_TO));
    chk("a_fail_code", 64'(a_fail_code), 64'(m_code));
    chk("a_fail_hart", 64'(a_fail_hart), 64'(m_hart));
    chk("a_hart_done", 64'(a_hart_done), 64'(m_done));
    chk("a_cycle_count", 64'(a_cnt), 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_a();
  endtask

  task automatic clr_a();
    a_start = 1'b0;
    a_we    = '0;
    a_addr  = '0;
    a_wdata = '0;
  endtask

  task automatic wr_a(input int h, input logic [11:0] ad, input logic [31:0] d);
    a_we[h]              = 1'b1;
    a_addr[h*12 +: 12]   = ad;
    a_wdata[h*32 +: 32]  = d;
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    clr_a();
    b_start = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
    m_reset();
    #23;
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_b_cnt", 64'(b_cnt), 64'd0);

    // Randomized phase on the 4-hart instance.
    for (int c = 0; c < 400; c++) begin
      a_start = ($urandom_range(0, 5) == 0);
      for (int h = 0; h < NH; h++) begin
        a_we[h]            = $urandom_range(0, 1);
        a_addr[h*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h51E;
        r = $urandom_range(0, 31);
        if (r == 0)       a_wdata[h*32 +: 32] = $urandom | 32'h3;
        else if (r < 12)  a_wdata[h*32 +: 32] = $urandom & 32'hFFFF_FFFE;
        else              a_wdata[h*32 +: 32] = 32'h1;
      end
      tick();
    end
    clr_a();
    for (int c = 0; c < 10; c++) tick();

    // Timeout exactly TA edges after RUN entry, then re-arm.
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("to_entry_cnt", 64'(a_cnt), 64'd0);
    for (int c = 0; c < TA - 1; c++) tick();
    chk("to_edge7_busy", 64'(a_busy), 64'd1);
    tick();
    chk("to_timed_out", 64'(a_to), 64'd1);
    chk("to_cnt", 64'(a_cnt), 64'(TA));
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("rearm_busy", 64'(a_busy), 64'd1);
    chk("rearm_cnt", 64'(a_cnt), 64'd0);

    // Completion in the last budget cycle wins over timeout.
    for (int c = 0; c < TA - 1; c++) tick();
    chk("last_cyc_cnt", 64'(a_cnt), 64'(TA - 1));
    for (int h = 0; h < NH; h++) wr_a(h, 12'h51E, 32'h1);
    tick();
    clr_a();
    chk("last_pass", 64'(a_pass), 64'd1);
    chk("last_not_to", 64'(a_to), 64'd0);
    chk("last_cnt", 64'(a_cnt), 64'(TA));

    // Partial pass keeps busy; a same-cycle fail beats the final pass.
    a_start = 1'b1; tick(); a_start = 1'b0;
    wr_a(0, 12'h51E, 32'h1); wr_a(2, 12'h51E, 32'h1); wr_a(3, 12'h51E, 32'h1);
    tick(); clr_a();
    chk("hd3_busy", 64'(a_busy), 64'd1);
    chk("hd3_mask", 64'(a_hart_done), 64'hD);
    wr_a(1, 12'h51E, 32'h1); wr_a(3, 12'h51E, 32'h9);
    tick(); clr_a();
    chk("mix_fail_done", 64'(a_done), 64'd1);
    chk("mix_pass", 64'(a_pass), 64'd0);
    chk("mix_fail_hart", 64'(a_fail_hart), 64'd3);
    chk("mix_fail_code", 64'(a_fail_code), 64'd4);

    // Single-hart instance: pass after 50 cycles, then a failing test 3.
    b_start = 1'b1; tick(); b_start = 1'b0;
    chk("b_busy", 64'(b_busy), 64'd1);
    for (int c = 0; c < 50; c++) tick();
    b_we = 1'b1; b_addr = 12'h51E; b_wdata = 32'h1;
    tick();
    b_we = 1'b0; b_addr = '0; b_wdata = '0;
    chk("b_pass", 64'(b_pass), 64'd1);
    chk("b_done", 64'(b_done), 64'd1);
    chk("b_cnt51", 64'(b_cnt), 64'd51);
    b_start = 1'b1; tick(); b_start = 1'b0;
    b_we = 1'b1; b_addr = 12'h51E; b_wdata = 32'h7;
    tick();
    b_we = 1'b0; b_addr = '0; b_wdata = '0;
    chk("b_fail_done", 64'(b_done), 64'd1);
    chk("b_fail_pass", 64'(b_pass), 64'd0);
    chk("b_fail_code", 64'(b_fail_code), 64'd3);
    chk("b_fail_hart", 64'(b_fail_hart), 64'd0);

    // Asynchronous reset mid-RUN clears everything before the next edge.
    a_start = 1'b1; tick(); a_start = 1'b0;
    wr_a(0, 12'h51E, 32'h1); wr_a(2, 12'h51E, 32'h1);
    tick(); clr_a();
    chk("rst_pre_hd", 64'(a_hart_done), 64'h5);
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_busy", 64'(a_busy), 64'd0);
    chk("arst_hd", 64'(a_hart_done), 64'd0);
    chk("arst_cnt", 64'(a_cnt), 64'd0);
    chk("arst_b_done", 64'(b_done), 64'd0);
    chk("arst_b_code", 64'(b_fail_code), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int h = 0; h < NH; h++) wr_a(h, 12'h51E, 32'h1);
    tick(); clr_a();
    chk("prestart_hd", 64'(a_hart_done), 64'd0);
    chk("prestart_done", 64'(a_done), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Synthesizable multi-hart test-completion monitor. It snoops CSR write ports from one or more cores for writes to the `tohost` CSR (0x51E) and enforces a cycle-budget timeout. It latches a pass, fail or timeout verdict with the failing test number and hart index. It sits beside the `Riscv151` core(s) in ISA regression builds, so the same verdict logic serves simulation and on-FPGA self-test without a bench-side polling loop.

## Interface
Parameters:
- `NUM_HARTS`, 1: number of snooped CSR write ports.
- `XLEN`, 32: CSR data width.
- `TOHOST_ADDR`, 12'h51E: CSR address treated as `tohost`.
- `TIMEOUT_CYCLES`, 10000: RUN-cycle budget before the timeout verdict; must be ≥ 1.
- `CNT_W`, $clog2(TIMEOUT_CYCLES+1): cycle counter width (derived).
- `HART_W`, max(1, $clog2(NUM_HARTS)): hart index width (derived).

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle arm pulse.
- `csr_we`  in  NUM_HARTS  per-hart CSR write strobe.
- `csr_addr`  in  NUM_HARTS*12  per-hart CSR address; hart h occupies bits [12h+11:12h].
- `csr_wdata`  in  NUM_HARTS*XLEN  per-hart CSR write data.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is PASS, FAIL or TIMEOUT.
- `pass`  out  1  state is PASS.
- `timed_out`  out  1  state is TIMEOUT.
- `fail_code`  out  XLEN-1  latched wdata[XLEN-1:1] of the failing write.
- `fail_hart`  out  HART_W  index of the failing hart.
- `hart_done`  out  NUM_HARTS  per-hart pass flags.
- `cycle_count`  out  CNT_W  number of elapsed RUN cycles.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- IDLE: `start` → RUN. On entry, `hart_done`, `cycle_count`, `fail_code` and `fail_hart` clear.
- PASS, FAIL, TIMEOUT: `start` re-arms exactly as from IDLE. Otherwise the state holds indefinitely.
- RUN: `start` is ignored.
- A qualifying write from hart h in RUN is `csr_we[h]` high, address equal to `TOHOST_ADDR`, and wdata[0] equal to 1.
  - wdata[0] = 0, a non-matching address, or any write outside RUN: ignored.
  - wdata[XLEN-1:1] == 0: sets `hart_done[h]`. A repeat pass write from a hart already done has no effect.
  - Nonzero upper bits: failure. `fail_code` and `fail_hart` latch the code and index, and the state moves to FAIL. Failure counts even if that hart already passed.
- Priority within one RUN cycle, highest first: FAIL, then PASS, then TIMEOUT.
- Multiple failing harts in the same cycle: the lowest index is latched.
- PASS is taken when `hart_done` OR this cycle's passing writes covers all harts.
- Counter: RUN cycle k (first cycle k=0) shows `cycle_count` = k.
  - On a completion in cycle k, the count freezes at k+1.
  - With no completion in cycle k = TIMEOUT_CYCLES-1, the state moves to TIMEOUT and the count freezes at TIMEOUT_CYCLES. The counter never wraps.
- Reset, asserted at any time including mid-RUN: state IDLE and every output 0.

## Timing
- All outputs are registered; none is combinational from the inputs.
- The verdict is visible on the first `clk` edge after the qualifying write cycle, so latency is 1 cycle.
- `start` sampled at edge t gives `busy`=1 after edge t.
- With no completing write, TIMEOUT is reached exactly TIMEOUT_CYCLES edges after entering RUN.
- `rst_n` falling asynchronously clears all state. Release is synchronised externally. The first edge with `rst_n` high may sample `start`.

## Structure
- Shared package `tohost_pkg`:
  - state enum `tohost_state_e`
  - localparam `TOHOST_CSR_ADDR = 12'h51E`
  - function `is_tohost_pass(wdata)`
- No sub-module: the per-hart decode is a generate loop inside `tohost_monitor`.

## Test plan
- NUM_HARTS=1, TIMEOUT_CYCLES=10000: pulse `start`, then after 50 cycles write 0x51E ← 32'h1. Expect `pass`=1 and `done`=1 after 1 edge, `cycle_count`=51.
- Write 0x51E ← 32'h0000_0007. Expect FAIL with `fail_code`=3, `fail_hart`=0, `pass`=0.
- NUM_HARTS=4: harts 0, 2, 3 pass and `busy` stays 1. Then hart 1 passes and hart 3 writes 32'h9 in the same cycle. Expect FAIL with `fail_hart`=3, `fail_code`=4.
- TIMEOUT_CYCLES=8, no writes. Expect `timed_out`=1 exactly 8 edges after RUN entry, `cycle_count`=8. Then pulse `start` and expect `busy`=1, `cycle_count`=0.
- TIMEOUT_CYCLES=8, passing write in RUN cycle 7. Expect PASS, not TIMEOUT, with `cycle_count`=8.
- Assert `rst_n`=0 mid-RUN with `hart_done`=4'b0101. Expect all outputs 0 immediately, before the next edge. A write to 0x51E before `start` is ignored.
